// File: rtl/stage_1_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
// Requests are accepted on req & ready; responses return in request order on rvalid.
interface stage_1_fetch_if;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req_out,
        output imem_addr_out,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req_out,
        input  imem_addr_out,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/stage_1_fetch.sv
// Pipeline stage 1: fetch PC generation, in-order instruction requests, a small
// prefetch FIFO and the registered instruction/PC/bubble interface to decode.
// Redirects flush buffered words and count the stale in-flight responses to drop.
module stage_1_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSN   = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   redirect_enable,
    input  logic [31:0]            redirect_addr,
    stage_1_fetch_if.master        imem,
    output logic [31:0]            instruction_out,
    output logic [31:0]            pc_out,
    output logic                   discard_out
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

    // Control state
    logic [31:0]      fetch_pc_reg;     // address of the next request
    logic [31:0]      resp_pc_reg;      // PC belonging to the next kept response
    logic [CNT_W-1:0] outstanding_reg;  // accepted requests not yet answered
    logic [CNT_W-1:0] drop_cnt_reg;     // stale responses still to be thrown away
    logic [CNT_W-1:0] count_reg;        // FIFO occupancy
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;

    // Decode-facing output registers
    logic [31:0]      insn_reg;
    logic [31:0]      pc_reg;
    logic             discard_reg;

    // Prefetch storage (data only, no reset needed)
    logic [31:0]      fifo_insn [FIFO_DEPTH];
    logic [31:0]      fifo_pc   [FIFO_DEPTH];

    logic [CNT_W:0]   occupancy;
    logic             accept;
    logic             resp_valid;
    logic             keep;
    logic             advance;
    logic             pop;
    logic             bypass;
    logic             push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Buffered words plus in-flight requests must never exceed the FIFO size, so every
    // response always has a slot to land in. A response with nothing outstanding is a
    // leftover from before a reset and is ignored.
    assign occupancy  = {1'b0, count_reg} + {1'b0, outstanding_reg};
    assign imem.imem_req_out  = rst_n && !redirect_enable && (occupancy < DEPTH_OCC);
    assign imem.imem_addr_out = fetch_pc_reg;

    assign accept     = imem.imem_req_out && imem.imem_ready;
    assign resp_valid = imem.imem_rvalid && (outstanding_reg != '0);
    assign keep       = resp_valid && (drop_cnt_reg == '0);
    // A bubble is never held, otherwise decode's own discard-induced stall could deadlock.
    assign advance    = !stall || discard_reg;
    assign pop        = advance && (count_reg != '0);
    assign bypass     = advance && (count_reg == '0) && keep;
    assign push       = keep && !bypass && !redirect_enable;

    assign instruction_out = insn_reg;
    assign pc_out          = pc_reg;
    assign discard_out     = discard_reg;

    // Fetch/response bookkeeping and the output register; redirect overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            insn_reg        <= NOP_INSN;
            pc_reg          <= '0;
            discard_reg     <= 1'b1;
        end else if (redirect_enable) begin
            fetch_pc_reg    <= {redirect_addr[31:2], 2'b00};
            resp_pc_reg     <= {redirect_addr[31:2], 2'b00};
            // Everything still in flight after this cycle is stale, including nothing
            // for the response arriving right now (it is discarded here directly).
            outstanding_reg <= outstanding_reg - CNT_W'(resp_valid);
            drop_cnt_reg    <= outstanding_reg - CNT_W'(resp_valid);
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            insn_reg        <= NOP_INSN;
            discard_reg     <= 1'b1;
        end else begin
            if (accept) begin
                fetch_pc_reg <= fetch_pc_reg + 32'd4;
            end
            outstanding_reg <= outstanding_reg + CNT_W'(accept) - CNT_W'(resp_valid);
            if (resp_valid && (drop_cnt_reg != '0)) begin
                drop_cnt_reg <= drop_cnt_reg - 1'b1;
            end
            if (keep) begin
                resp_pc_reg <= resp_pc_reg + 32'd4;
            end
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);

            if (pop) begin
                insn_reg    <= fifo_insn[rd_ptr_reg];
                pc_reg      <= fifo_pc[rd_ptr_reg];
                discard_reg <= 1'b0;
            end else if (bypass) begin
                insn_reg    <= imem.imem_rdata;
                pc_reg      <= resp_pc_reg;
                discard_reg <= 1'b0;
            end else if (advance) begin
                insn_reg    <= NOP_INSN;
                discard_reg <= 1'b1;
            end
        end
    end

    // Prefetch FIFO write port: kept responses that could not go straight to decode.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_insn[wr_ptr_reg] <= imem.imem_rdata;
            fifo_pc[wr_ptr_reg]   <= resp_pc_reg;
        end
    end

endmodule
